// File: rtl/riscv_enc_pkg.sv
// riscv_enc_pkg: shared types, opcode map and encode helpers
// for the streaming RISC-V IMF instruction encoder.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_R4   = 3'd6,
    FMT_RSVD = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_LOAD_FP  = 7'h07;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_STORE_FP = 7'h27;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_MADD     = 7'h43;
  localparam logic [6:0] OPC_MSUB     = 7'h47;
  localparam logic [6:0] OPC_NMSUB    = 7'h4B;
  localparam logic [6:0] OPC_NMADD    = 7'h4F;
  localparam logic [6:0] OPC_OP_FP    = 7'h53;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  // Pack one request into a 32-bit word; reserved format yields 0.
  function automatic logic [31:0] encode(enc_req_t r);
    logic [31:0] w;
    logic [31:0] i;
    w = '0;
    i = r.imm;
    unique case (r.fmt)
      FMT_R:
        w = {r.funct7, r.rs2, r.rs1, r.funct3,
             r.rd, r.opcode};
      FMT_I:
        w = {i[11:0], r.rs1, r.funct3,
             r.rd, r.opcode};
      FMT_S:
        w = {i[11:5], r.rs2, r.rs1, r.funct3,
             i[4:0], r.opcode};
      FMT_B:
        w = {i[12], i[10:5], r.rs2, r.rs1,
             r.funct3, i[4:1], i[11], r.opcode};
      FMT_U:
        w = {i[31:12], r.rd, r.opcode};
      FMT_J:
        w = {i[20], i[10:1], i[11], i[19:12],
             r.rd, r.opcode};
      FMT_R4:
        w = {r.rs3, r.funct7[1:0], r.rs2, r.rs1,
             r.funct3, r.rd, r.opcode};
      default:
        w = '0;
    endcase
    return w;
  endfunction

  // True when the immediate fits the encoded field exactly.
  function automatic logic imm_ok(enc_req_t r);
    logic signed [31:0] s;
    logic ok;
    s  = r.imm;
    ok = 1'b1;
    unique case (r.fmt)
      FMT_I, FMT_S:
        ok = (s >= -32'sd2048) && (s <= 32'sd2047);
      FMT_B:
        ok = (s >= -32'sd4096) && (s <= 32'sd4094)
             && !r.imm[0];
      FMT_J:
        ok = (s >= -32'sd1048576)
             && (s <= 32'sd1048574) && !r.imm[0];
      FMT_U:
        ok = (r.imm[11:0] == 12'd0);
      default:
        ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/riscv_enc_fifo2.sv
// riscv_enc_fifo2: two-entry in-order FIFO with registered
// count; head is always entry 0, push and pop may coincide.
module riscv_enc_fifo2
  import riscv_enc_pkg::*;
#(
  parameter int W = 44
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_eff;
  logic         push_eff;
  logic [1:0]   left;

  assign pop_eff  = pop_i && (count_q != 2'd0);
  assign left     = count_q - {1'b0, pop_eff};
  assign push_eff = push_i && (left != 2'd2);

  // Shift on pop, then write the push into the first free slot.
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = left;
    if (pop_eff) begin
      mem0_d = mem1_q;
    end
    if (push_eff) begin
      if (left == 2'd0) begin
        mem0_d = data_i;
      end else begin
        mem1_d = data_i;
      end
      count_d = left + 2'd1;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign data_o  = mem0_q;
  assign count_o = count_q;

endmodule

// File: rtl/riscv_insn_encoder.sv
// riscv_insn_encoder: field requests -> tagged 32-bit words.
// Optional RISCV_ENC_IMM_CHECK_EN drops out-of-range immediates.
module riscv_insn_encoder
  import riscv_enc_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [4:0]            in_rs3,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] addr_load_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_insn,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [1:0]            err,
  input  logic                  err_clear
);

  localparam int PW = ADDR_WIDTH + 32;

  enc_req_t              req;
  logic                  accept;
  logic                  rsvd;
  logic                  imm_bad;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] tag;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]            err_q, err_d;
  logic [1:0]            count;
  logic [PW-1:0]         head;
  logic [PW-1:0]         entry;

  assign req = '{
    fmt:    fmt_e'(in_fmt),
    opcode: in_opcode,
    rd:     in_rd,
    rs1:    in_rs1,
    rs2:    in_rs2,
    rs3:    in_rs3,
    funct3: in_funct3,
    funct7: in_funct7,
    imm:    in_imm
  };

  assign in_ready = reset_n && (count != 2'd2);
  assign accept   = in_valid && in_ready;
  assign rsvd     = (req.fmt == FMT_RSVD);

`ifdef RISCV_ENC_IMM_CHECK_EN
  assign imm_bad = !rsvd && !imm_ok(req);
`else
  assign imm_bad = 1'b0;
`endif

  assign push  = accept && !rsvd && !imm_bad;
  assign pop   = out_valid && out_ready;
  assign tag   = addr_load ? addr_load_value : cnt_q;
  assign entry = {tag, encode(req)};

  // Counter follows a load, and advances only past a pushed word.
  always_comb begin
    cnt_d = tag;
    if (push) begin
      cnt_d = tag + ADDR_WIDTH'(1);
    end
  end

  // Sticky errors; a fresh error overrides a same-cycle clear.
  always_comb begin
    err_d = err_clear ? 2'b00 : err_q;
    if (accept && rsvd) begin
      err_d[0] = 1'b1;
    end
    if (accept && imm_bad) begin
      err_d[1] = 1'b1;
    end
  end

  // Address counter and error flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 2'b00;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  riscv_enc_fifo2 #(
    .W (PW)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push),
    .data_i  (entry),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (count)
  );

  assign out_valid = (count != 2'd0);
  assign out_insn  = head[31:0];
  assign out_addr  = head[PW-1:32];
  assign err       = err_q;

endmodule

// File: tb/tb_riscv_insn_encoder.sv
// tb_riscv_insn_encoder: directed vectors, queue-based model
// and a per-cycle compare process for riscv_insn_encoder.
module tb_riscv_insn_encoder;

  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [4:0]    in_rs3 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          addr_load = 1'b0;
  logic [AW-1:0] addr_load_value = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_insn;
  logic [AW-1:0] out_addr;
  logic [1:0]    err;
  logic          err_clear = 1'b0;

  always #5 clock = ~clock;

  riscv_insn_encoder #(
    .ADDR_WIDTH (AW)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_fmt          (in_fmt),
    .in_opcode       (in_opcode),
    .in_rd           (in_rd),
    .in_rs1          (in_rs1),
    .in_rs2          (in_rs2),
    .in_rs3          (in_rs3),
    .in_funct3       (in_funct3),
    .in_funct7       (in_funct7),
    .in_imm          (in_imm),
    .addr_load       (addr_load),
    .addr_load_value (addr_load_value),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_insn        (out_insn),
    .out_addr        (out_addr),
    .err             (err),
    .err_clear       (err_clear)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference encoding built from field positions by arithmetic.
  function automatic logic [31:0] model_enc(
      int fmt, int op, int rd, int rs1, int rs2,
      int rs3, int f3, int f7, int imm);
    longint v;
    longint b;
    v = op & 'h7F;
    case (fmt)
      0: v += (f7 * (1 << 25)) + (rs2 * (1 << 20))
            + (rs1 * (1 << 15)) + (f3 * (1 << 12))
            + (rd * (1 << 7));
      1: v += ((imm & 'hFFF) * (1 << 20))
            + (rs1 * (1 << 15)) + (f3 * (1 << 12))
            + (rd * (1 << 7));
      2: v += (((imm >> 5) & 'h7F) * (1 << 25))
            + (rs2 * (1 << 20)) + (rs1 * (1 << 15))
            + (f3 * (1 << 12)) + ((imm & 'h1F) * (1 << 7));
      3: begin
        b = 0;
        for (int k = 1; k <= 12; k++) begin
          if (((imm >> k) & 1) != 0) begin
            if (k == 12) b += longint'(1) << 31;
            else if (k == 11) b += 1 << 7;
            else if (k >= 5) b += 1 << (k + 20);
            else b += 1 << (k + 7);
          end
        end
        v += b + (rs2 * (1 << 20)) + (rs1 * (1 << 15))
             + (f3 * (1 << 12));
      end
      4: v += (longint'(imm) & 'hFFFFF000)
            + (rd * (1 << 7));
      5: begin
        b = 0;
        for (int k = 1; k <= 20; k++) begin
          if (((imm >> k) & 1) != 0) begin
            if (k == 20) b += longint'(1) << 31;
            else if (k == 11) b += 1 << 20;
            else if (k >= 12) b += 1 << k;
            else b += 1 << (k + 20);
          end
        end
        v += b + (rd * (1 << 7));
      end
      6: v += (longint'(rs3) * (1 << 27))
            + ((f7 & 3) * (1 << 25)) + (rs2 * (1 << 20))
            + (rs1 * (1 << 15)) + (f3 * (1 << 12))
            + (rd * (1 << 7));
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic bit model_legal(int fmt, int imm);
`ifdef RISCV_ENC_IMM_CHECK_EN
    case (fmt)
      1, 2: return imm >= -2048 && imm <= 2047;
      3: return imm >= -4096 && imm <= 4094
                && (imm % 2) == 0;
      5: return imm >= -1048576 && imm <= 1048574
                && (imm % 2) == 0;
      4: return (imm % 4096) == 0;
      default: return 1'b1;
    endcase
`else
    return (fmt >= 0);
`endif
  endfunction

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   w;
  } ent_t;

  ent_t       mq[$];
  int         mcnt = 0;
  logic [1:0] merr = 2'b00;
  bit         macc;
  int         mbase;
  ent_t       ment;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      mcnt = 0;
      merr = 2'b00;
    end else begin
      macc = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      mbase = addr_load ? int'(addr_load_value) : mcnt;
      if (err_clear) merr = 2'b00;
      mcnt = mbase;
      if (macc) begin
        if (in_fmt == 3'd7) begin
          merr[0] = 1'b1;
        end else if (!model_legal(int'(in_fmt),
                                  int'($signed(in_imm)))) begin
          merr[1] = 1'b1;
        end else begin
          ment.a = AW'(mbase);
          ment.w = model_enc(int'(in_fmt), int'(in_opcode),
                             int'(in_rd), int'(in_rs1),
                             int'(in_rs2), int'(in_rs3),
                             int'(in_funct3), int'(in_funct7),
                             int'($signed(in_imm)));
          mq.push_back(ment);
          mcnt = (mbase + 1) % (1 << AW);
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("in_ready", {63'd0, in_ready},
        {63'd0, reset_n && (mq.size() < 2)});
    chk("out_valid", {63'd0, out_valid},
        {63'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("out_insn", {32'd0, out_insn}, {32'd0, mq[0].w});
      chk("out_addr", {52'd0, out_addr}, {52'd0, mq[0].a});
    end
    chk("err", {62'd0, err}, {62'd0, merr});
  end

  task automatic send(input int fmt, input int op,
                      input int rd, input int rs1,
                      input int rs2, input int rs3,
                      input int f3, input int f7,
                      input int imm);
    int  t;
    bit  ok;
    t = 0;
    in_fmt    = 3'(fmt);
    in_opcode = 7'(op);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_rs3    = 5'(rs3);
    in_funct3 = 3'(f3);
    in_funct7 = 7'(f7);
    in_imm    = 32'(imm);
    in_valid  = 1'b1;
    forever begin
      ok = in_ready;
      @(posedge clock);
      if (ok) break;
      t++;
      if (t > 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stuck 0");
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic lit(input string nm,
                     input logic [31:0] w,
                     input logic [AW-1:0] a);
    chk({nm, "_v"}, {63'd0, out_valid}, 64'd1);
    chk({nm, "_w"}, {32'd0, out_insn}, {32'd0, w});
    chk({nm, "_a"}, {52'd0, out_addr}, {52'd0, a});
  endtask

  initial begin
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_insn", {32'd0, out_insn}, 64'd0);
    chk("rst_addr", {52'd0, out_addr}, 64'd0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_err", {62'd0, err}, 64'd0);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("ready_up", {63'd0, in_ready}, 64'd1);

    send(1, 'h13, 1, 0, 0, 0, 0, 0, 5);
    lit("addi", 32'h00500093, 12'h000);
    send(2, 'h23, 0, 1, 2, 0, 2, 0, 8);
    lit("sw", 32'h0020A423, 12'h001);
    send(3, 'h63, 0, 0, 0, 0, 0, 0, -4);
    lit("beq", 32'hFE000EE3, 12'h002);
    send(5, 'h6F, 1, 0, 0, 0, 0, 0, 2048);
    lit("jal", 32'h001000EF, 12'h003);
    send(0, 'h33, 3, 4, 5, 0, 0, 'h20, 0);
    lit("sub", 32'h405201B3, 12'h004);
    send(4, 'h37, 5, 0, 0, 0, 0, 0, 'h12345000);
    lit("lui", 32'h123452B7, 12'h005);
    send(6, 'h43, 1, 2, 3, 4, 0, 'h7C, 0);
    lit("fmadd", 32'h203100C3, 12'h006);
    send(1, 'h13, 1, 0, 0, 0, 0, 0, -2048);
    lit("imm_min", 32'h80000093, 12'h007);

    send(7, 'h13, 1, 0, 0, 0, 0, 0, 1);
    chk("rsvd_err", {62'd0, err}, 64'd1);
    chk("rsvd_nov", {63'd0, out_valid}, 64'd0);
    send(1, 'h13, 2, 0, 0, 0, 0, 0, 1);
    lit("after_rsvd", 32'h00100113, 12'h008);
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;
    chk("err_clr", {62'd0, err}, 64'd0);

    addr_load = 1'b1;
    addr_load_value = 12'h040;
    send(1, 'h13, 1, 0, 0, 0, 0, 0, 5);
    addr_load = 1'b0;
    lit("load40", 32'h00500093, 12'h040);
    send(1, 'h13, 1, 0, 0, 0, 0, 0, 5);
    lit("load41", 32'h00500093, 12'h041);
    addr_load = 1'b1;
    addr_load_value = 12'hFFF;
    @(negedge clock);
    addr_load = 1'b0;
    send(1, 'h13, 1, 0, 0, 0, 0, 0, 5);
    lit("wrap_fff", 32'h00500093, 12'hFFF);
    send(1, 'h13, 1, 0, 0, 0, 0, 0, 5);
    lit("wrap_000", 32'h00500093, 12'h000);

    send(1, 'h13, 1, 0, 0, 0, 0, 0, 4096);
`ifdef RISCV_ENC_IMM_CHECK_EN
    chk("imm_err", {62'd0, err}, 64'd2);
    chk("imm_nov", {63'd0, out_valid}, 64'd0);
    send(1, 'h13, 1, 0, 0, 0, 0, 0, 5);
    lit("imm_cnt", 32'h00500093, 12'h001);
`else
    chk("imm_err", {62'd0, err}, 64'd0);
    lit("imm_trunc", 32'h00000093, 12'h001);
`endif
    err_clear = 1'b1;
    @(negedge clock);
    err_clear = 1'b0;

    out_ready = 1'b0;
    send(1, 'h13, 1, 0, 0, 0, 0, 0, 11);
    send(1, 'h13, 1, 0, 0, 0, 0, 0, 12);
    #2 reset_n = 1'b0;
    @(negedge clock);
    chk("mid_rst_v", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_r", {63'd0, in_ready}, 64'd0);
    #2 reset_n = 1'b1;
    @(negedge clock);

    fork
      begin
        send(1, 'h13, 1, 0, 0, 0, 0, 0, 1);
        send(1, 'h13, 1, 0, 0, 0, 0, 0, 2);
        send(1, 'h13, 1, 0, 0, 0, 0, 0, 3);
        send(1, 'h13, 1, 0, 0, 0, 0, 0, 4);
      end
      begin
        repeat (6) @(negedge clock);
        chk("bp_ready", {63'd0, in_ready}, 64'd0);
        lit("bp_head", 32'h00100093, 12'h000);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clock);
    chk("drained", {63'd0, out_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_insn_encoder.md
# riscv_insn_encoder

Streaming RISC-V IMF instruction encoder: the inverse of the instruction decoder. It accepts field-level instruction requests (format class, opcode, register indices, funct fields, immediate) over a valid/ready handshake. It packs each request into a 32-bit instruction word, tags it with an auto-incrementing instruction-memory word address, and buffers it in a 2-entry output FIFO. The shader loader / patch unit uses it to write generated code into GPU instruction RAM.

## Interface
- ADDR_WIDTH, default 12: width of instruction-memory word address.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at the rising edge.
- in_fmt  in  3  format class: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 R4, 7 reserved.
- in_opcode  in  7  opcode, placed verbatim in inst[6:0].
- in_rd / in_rs1 / in_rs2 / in_rs3  in  5 each  register indices.
- in_funct3  in  3  funct3 / rounding mode.
- in_funct7  in  7  funct7; for R4, bits [1:0] form fmt.
- in_imm  in  32  signed immediate, byte offset; for U, the full upper value.
- addr_load  in  1  load address counter.
- addr_load_value  in  ADDR_WIDTH  value loaded into the counter.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops the head when out_valid && out_ready.
- out_insn  out  32  encoded instruction at the FIFO head.
- out_addr  out  ADDR_WIDTH  word address of the FIFO head.
- err  out  2  sticky flags: [0] reserved format, [1] immediate out of range.
- err_clear  in  1  synchronous clear of err.

## Operation
- Encoding, by format:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - R4: {rs3, funct7[1:0], rs2, rs1, funct3, rd, opcode}.
  - Unused inputs are ignored.
- Format 7: the request is accepted and dropped. err[0] is set, and the counter does not advance.
- Accept path:
  - The word is encoded combinationally and pushed into the FIFO together with the current counter value.
  - The counter then advances by 1 and wraps modulo 2^ADDR_WIDTH.
- addr_load:
  - The counter takes addr_load_value.
  - If a request is accepted in the same cycle, it is tagged with addr_load_value and the counter becomes addr_load_value+1.
  - Entries already in the FIFO keep their tags.
- FIFO: 2 entries, strict order. in_ready = (count < 2); it depends only on registered state, with no combinational path from out_ready. Push and pop may occur in the same cycle.
- err_clear and a new error in the same cycle: the new error wins.

## Timing
- Reset values: out_valid 0, out_insn 0, out_addr 0, err 0, counter 0, FIFO empty. in_ready is 0 while reset_n is low and 1 in the first cycle after release.
- Latency: a request accepted at edge N is visible on out_valid/out_insn at N+1 when the FIFO was empty.
- Throughput: 1 instruction per cycle sustained while out_ready stays high.
- FIFO full (count 2): in_ready = 0. A pop at edge N raises in_ready after N.
- out_insn and out_addr are held stable while out_valid && !out_ready.
- Reset asserted mid-stream discards FIFO contents immediately.

## Configuration
- RISCV_ENC_IMM_CHECK_EN defined: range checks are applied, and a failing request is dropped, sets err[1], and does not advance the counter. The checks are:
  - I/S: -2048..2047.
  - B: -4096..4094 and even.
  - J: -1048576..1048574 and even.
  - U: imm[11:0] == 0.
- RISCV_ENC_IMM_CHECK_EN undefined: immediates are silently truncated to the encoded bits, and err[1] is tied to 0.

## Structure
- Package riscv_enc_pkg holds:
  - the format enum (FMT_R..FMT_R4, FMT_RSVD);
  - opcode constants matching the decoder's opcode map;
  - the combinational encode function, so benches can reuse it as a reference model.
- Sub-module riscv_enc_fifo2: 2-entry FIFO, {addr, insn} payload, with count, push and pop.

## Test plan
- I ADDI: opcode 0x13, rd 1, rs1 0, funct3 0, imm 5 -> out_insn 0x00500093, out_addr 0, out_valid one cycle after accept.
- S SW: opcode 0x23, rs1 1, rs2 2, funct3 2, imm 8 -> 0x0020A423. B BEQ: opcode 0x63, rs1 0, rs2 0, funct3 0, imm -4 -> 0xFE000EE3.
- J JAL: opcode 0x6F, rd 1, imm 2048 -> 0x001000EF. Decoding it back through the decoder yields imm_jump 2048 and rd 1.
- Backpressure: out_ready 0 and 4 back-to-back requests -> 2 accepted, in_ready 0. Releasing out_ready yields addresses 0,1 in order, then the remaining two with addresses 2,3.
- addr_load 0x40 in the same cycle as an accept -> that word has out_addr 0x40 and the next accepted word has 0x41. Format 7 -> err = 2'b01, no output, counter unchanged.
- I-format imm 4096 (opcode 0x13, rd 1):
  - with the macro: dropped, err[1] = 1, counter unchanged;
  - without the macro: emits 0x00000093.
